swt_frame_conditioner: RTL and testbench
========================================

Name: swt_frame_conditioner

Overview:
- Conditions the three colour/text-select slide switches before they reach the font/text pixel generator.
- Each switch passes through a 2-FF synchronizer and a per-bit debouncer.
- The cleaned value is applied only at the start of vertical retrace, so a switch change never alters colours mid-frame (no tearing).
- Sits between the board switch pins and the switch inputs of the text generator, and shares the system clock and the vsync from the VGA sync stage.

Parameters:
- DB_CYCLES, 1000000: clock cycles an input must hold a new level before it is accepted (20 ms at 50 MHz). Legal range is ≥2.
- CNT_W, 20: debounce counter width. Must satisfy 2^CNT_W > DB_CYCLES.
- VS_POL, 1: active level of the vsync input (1 = high during retrace).

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- swt_in  in  3  raw switch levels, asynchronous to clk; bit0=swt1, bit1=swt2, bit2=swt3.
- vsync  in  1  vertical sync from the VGA sync stage, synchronous to clk.
- swt_out  out  3  frame-aligned, debounced switch levels to the text generator.
- frame_tick  out  1  one-cycle pulse on the clock edge where vsync enters its active level.
- changed  out  1  one-cycle pulse, coincident with frame_tick, when swt_out took a value different from its previous one.

Behaviour:
- Reset (reset=0, asynchronous): every internal register and output is cleared.
  - Sync flops, debounced state db[2:0] and all counters go to 0.
  - swt_out=3'b000, frame_tick=0, changed=0.
  - The vsync delay register vs_d resets to the active level VS_POL. Consequence: no frame_tick is issued until vsync has been seen inactive and then active after reset release.
- Synchronizer: s1 <= swt_in, then s2 <= s1, per bit.
- Debouncer (independent per bit i, counter cnt_i):
  - If s2[i]==db[i], cnt_i <= 0.
  - Otherwise, if cnt_i == DB_CYCLES-1, then db[i] <= s2[i] and cnt_i <= 0.
  - Otherwise cnt_i <= cnt_i+1.
- Debounce latency: a clean input step sampled at edge k reaches db at edge k+1+DB_CYCLES.
- Glitch rejection: a pulse lasting fewer than DB_CYCLES cycles at s2 returns cnt_i to 0 and leaves db unchanged. The counter restarts on every bounce.
- Frame alignment: vs_d <= vsync every cycle. start = (vsync==VS_POL) && (vs_d!=VS_POL).
  - On an edge where start=1: frame_tick <= 1, swt_out <= db, changed <= (db != swt_out).
  - On all other edges: frame_tick <= 0, changed <= 0, swt_out holds.
- Simultaneous events:
  - If db updates on the same edge as start, swt_out captures the pre-edge db value. The new value is applied at the next frame start.
  - Different bits may settle in different frames. Each bit is applied at the first frame start after it settles.
- No output is combinational from any input; all outputs are registered.
- vsync held permanently active or inactive: no frame_tick, and swt_out stays frozen.
- Reset asserted mid-debounce or mid-frame: all state is lost immediately. After release, swt_out stays 0 until the first valid frame start, even if the switches are high.
- Counter wrap cannot occur: cnt_i never exceeds DB_CYCLES-1.

Test Plan:
- DB_CYCLES=4, VS_POL=1. Hold reset=0 with swt_in=3'b111 and vsync=1, then release → swt_out=0 and frame_tick=0 until vsync goes 0 then 1. At that frame start: frame_tick=1 for 1 cycle, swt_out=3'b111, changed=1.
- swt_in[0] steps 0→1, sampled at edge k → db[0] rises at edge k+5. swt_out[0] stays 0 until the next vsync rise, then goes 1 with changed=1.
- swt_in[1] bounce: high 3 cycles, low 2, high 3, then low → db[1] never changes, and the next frame start gives changed=0 with swt_out unchanged.
- db[2] settles on the exact edge where vsync rises → that frame's tick leaves swt_out[2] old and changed=0. The following frame start sets swt_out[2] new with changed=1.
- Two frame starts with constant switches → frame_tick pulses each time, changed=0 both times.
- Assert reset mid-count (cnt=2) with swt_out=3'b101 → swt_out=0 immediately. After release, 4 stable cycles plus a frame start restore 3'b101.

Source files
------------

// File: rtl/swt_frame_conditioner.sv
// Switch conditioner: the three raw slide switches are synchronized and debounced
// per bit, and the cleaned value is only applied to swt_out at the start of vertical retrace.
module swt_frame_conditioner #(
    parameter int DB_CYCLES = 1000000,
    parameter int CNT_W     = 20,
    parameter int VS_POL    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] swt_in,
    input  logic       vsync,
    output logic [2:0] swt_out,
    output logic       frame_tick,
    output logic       changed
);

    localparam logic             VS_ACT   = (VS_POL != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [2:0] s1_q, s1_d;
    logic [2:0] s2_q, s2_d;
    logic [2:0] db;

    always_comb begin
        s1_d = swt_in;
        s2_d = s1_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    // Each bit must hold a new level for DB_CYCLES consecutive cycles; any bounce restarts the count.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_db
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             db_q, db_d;

            always_comb begin
                cnt_d = cnt_q;
                db_d  = db_q;
                if (s2_q[gi] == db_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    db_d  = s2_q[gi];
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt_q <= '0;
                    db_q  <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    db_q  <= db_d;
                end
            end

            assign db[gi] = db_q;
        end
    endgenerate

    logic       vs_d_q, vs_d_d;
    logic [2:0] swt_out_q, swt_out_d;
    logic       frame_tick_q, frame_tick_d;
    logic       changed_q, changed_d;
    logic       start;

    // vs_d resets to the active level so a vsync already active at release is not a frame start.
    assign start = (vsync == VS_ACT) && (vs_d_q != VS_ACT);

    always_comb begin
        vs_d_d       = vsync;
        swt_out_d    = swt_out_q;
        frame_tick_d = 1'b0;
        changed_d    = 1'b0;
        if (start) begin
            frame_tick_d = 1'b1;
            swt_out_d    = db;
            changed_d    = (db != swt_out_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vs_d_q       <= VS_ACT;
            swt_out_q    <= '0;
            frame_tick_q <= 1'b0;
            changed_q    <= 1'b0;
        end else begin
            vs_d_q       <= vs_d_d;
            swt_out_q    <= swt_out_d;
            frame_tick_q <= frame_tick_d;
            changed_q    <= changed_d;
        end
    end

    assign swt_out    = swt_out_q;
    assign frame_tick = frame_tick_q;
    assign changed    = changed_q;

endmodule

// File: tb/tb_swt_frame_conditioner.sv
// Bench for swt_frame_conditioner with a short debounce window (DB_CYCLES=4).
module tb_swt_frame_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] swt_in;
    logic       vsync;
    logic [2:0] swt_out;
    logic       frame_tick;
    logic       changed;

    swt_frame_conditioner #(
        .DB_CYCLES(4),
        .CNT_W    (3),
        .VS_POL   (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .swt_in    (swt_in),
        .vsync     (vsync),
        .swt_out   (swt_out),
        .frame_tick(frame_tick),
        .changed   (changed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] swt;
        logic       vs;
        int         n;
        logic [2:0] out;
        logic       tick;
        logic       chg;
    } vec_t;

    typedef struct {
        string      name;
        logic [2:0] out;
        logic       tick;
        logic       chg;
    } exp_t;

    vec_t tbl_a[$];
    vec_t tbl_b[$];
    exp_t sb[$];
    int   ntests = 0;
    int   nfail  = 0;

    function automatic vec_t mk(input logic [2:0] swt, input logic vs, input int n,
                                input logic [2:0] out, input logic tick, input logic chg);
        vec_t v;
        v.swt = swt; v.vs = vs; v.n = n; v.out = out; v.tick = tick; v.chg = chg;
        return v;
    endfunction

    task automatic push_exp(input string name, input logic [2:0] out, input logic tick, input logic chg);
        exp_t e;
        e.name = name; e.out = out; e.tick = tick; e.chg = chg;
        sb.push_back(e);
    endtask

    task automatic check_pop();
        exp_t e;
        ntests++;
        if (sb.size() == 0) begin
            nfail++;
            $display("FAIL scoreboard_empty: got no expectation, required one");
        end else begin
            e = sb.pop_front();
            if (swt_out !== e.out || frame_tick !== e.tick || changed !== e.chg) begin
                nfail++;
                $display("FAIL %s: got out=%b tick=%b chg=%b, required out=%b tick=%b chg=%b",
                         e.name, swt_out, frame_tick, changed, e.out, e.tick, e.chg);
            end else begin
                $display("ok   %s: out=%b tick=%b chg=%b", e.name, swt_out, frame_tick, changed);
            end
        end
    endtask

    // Called at a negedge: drive, run n rising edges, sample at the following negedge.
    task automatic apply(input string tag, input int idx, input vec_t v);
        swt_in = v.swt;
        vsync  = v.vs;
        push_exp($sformatf("%s[%0d] swt=%b vs=%b n=%0d", tag, idx, v.swt, v.vs, v.n), v.out, v.tick, v.chg);
        repeat (v.n) @(posedge clk);
        @(negedge clk);
        check_pop();
    endtask

    initial begin
        // release with switches high and vsync active, then first frame start
        tbl_a.push_back(mk(3'b111, 1'b1, 8,  3'b000, 1'b0, 1'b0));
        tbl_a.push_back(mk(3'b111, 1'b0, 2,  3'b000, 1'b0, 1'b0));
        tbl_a.push_back(mk(3'b111, 1'b1, 1,  3'b111, 1'b1, 1'b1));
        tbl_a.push_back(mk(3'b111, 1'b1, 1,  3'b111, 1'b0, 1'b0));
        // bit0 step: not applied until the frame after it settles
        tbl_a.push_back(mk(3'b110, 1'b0, 8,  3'b111, 1'b0, 1'b0));
        tbl_a.push_back(mk(3'b110, 1'b1, 1,  3'b110, 1'b1, 1'b1));
        tbl_a.push_back(mk(3'b111, 1'b0, 3,  3'b110, 1'b0, 1'b0));
        tbl_a.push_back(mk(3'b111, 1'b1, 1,  3'b110, 1'b1, 1'b0));
        tbl_a.push_back(mk(3'b111, 1'b1, 3,  3'b110, 1'b0, 1'b0));
        tbl_a.push_back(mk(3'b111, 1'b0, 1,  3'b110, 1'b0, 1'b0));
        tbl_a.push_back(mk(3'b111, 1'b1, 1,  3'b111, 1'b1, 1'b1));
        // bit1 bounce: 3 high, 2 low, 3 high, low
        tbl_a.push_back(mk(3'b101, 1'b0, 8,  3'b111, 1'b0, 1'b0));
        tbl_a.push_back(mk(3'b101, 1'b1, 1,  3'b101, 1'b1, 1'b1));
        tbl_a.push_back(mk(3'b111, 1'b1, 3,  3'b101, 1'b0, 1'b0));
        tbl_a.push_back(mk(3'b101, 1'b1, 2,  3'b101, 1'b0, 1'b0));
        tbl_a.push_back(mk(3'b111, 1'b1, 3,  3'b101, 1'b0, 1'b0));
        tbl_a.push_back(mk(3'b101, 1'b1, 6,  3'b101, 1'b0, 1'b0));
        tbl_a.push_back(mk(3'b101, 1'b0, 1,  3'b101, 1'b0, 1'b0));
        tbl_a.push_back(mk(3'b101, 1'b1, 1,  3'b101, 1'b1, 1'b0));
        // bit2 settles on the exact frame-start edge
        tbl_a.push_back(mk(3'b001, 1'b1, 4,  3'b101, 1'b0, 1'b0));
        tbl_a.push_back(mk(3'b001, 1'b0, 1,  3'b101, 1'b0, 1'b0));
        tbl_a.push_back(mk(3'b001, 1'b1, 1,  3'b101, 1'b1, 1'b0));
        tbl_a.push_back(mk(3'b001, 1'b0, 1,  3'b101, 1'b0, 1'b0));
        tbl_a.push_back(mk(3'b001, 1'b1, 1,  3'b001, 1'b1, 1'b1));
        // constant switches over two frames, vsync held in each level
        tbl_a.push_back(mk(3'b001, 1'b0, 2,  3'b001, 1'b0, 1'b0));
        tbl_a.push_back(mk(3'b001, 1'b1, 1,  3'b001, 1'b1, 1'b0));
        tbl_a.push_back(mk(3'b001, 1'b1, 5,  3'b001, 1'b0, 1'b0));
        tbl_a.push_back(mk(3'b001, 1'b0, 10, 3'b001, 1'b0, 1'b0));
        tbl_a.push_back(mk(3'b001, 1'b1, 1,  3'b001, 1'b1, 1'b0));
        tbl_a.push_back(mk(3'b001, 1'b1, 1,  3'b001, 1'b0, 1'b0));
        // reach 101, then start a bit1 count to 2
        tbl_a.push_back(mk(3'b101, 1'b0, 8,  3'b001, 1'b0, 1'b0));
        tbl_a.push_back(mk(3'b101, 1'b1, 1,  3'b101, 1'b1, 1'b1));
        tbl_a.push_back(mk(3'b111, 1'b0, 4,  3'b101, 1'b0, 1'b0));
        // recovery after mid-count reset
        tbl_b.push_back(mk(3'b101, 1'b0, 8,  3'b000, 1'b0, 1'b0));
        tbl_b.push_back(mk(3'b101, 1'b1, 1,  3'b101, 1'b1, 1'b1));
        tbl_b.push_back(mk(3'b101, 1'b1, 1,  3'b101, 1'b0, 1'b0));

        reset  = 1'b0;
        swt_in = 3'b111;
        vsync  = 1'b1;
        repeat (3) @(negedge clk);
        push_exp("in_reset", 3'b000, 1'b0, 1'b0);
        check_pop();
        reset = 1'b1;

        for (int i = 0; i < tbl_a.size(); i++) apply("a", i, tbl_a[i]);

        // asynchronous reset in the middle of a cycle must clear outputs at once
        #2;
        reset = 1'b0;
        #1;
        push_exp("async_reset_mid_count", 3'b000, 1'b0, 1'b0);
        check_pop();
        @(negedge clk);
        swt_in = 3'b101;
        vsync  = 1'b0;
        reset  = 1'b1;

        for (int i = 0; i < tbl_b.size(); i++) apply("b", i, tbl_b[i]);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
